// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - write-back FIFO ahead of the register-file write port, with decode forwarding.
// Optional forwarding comparators are compiled in when WB_FWD_EN is defined.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4:0]                  in_rd,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        wb_stall,
    output logic                        reg_wen,
    output logic [4:0]                  rd,
    output logic [DATA_W-1:0]           reg_in,
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    output logic                        fwd1_hit,
    output logic                        fwd2_hit,
    output logic [DATA_W-1:0]           fwd1_data,
    output logic [DATA_W-1:0]           fwd2_data,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        mem_rd_q   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              reg_wen_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] reg_in_q;
    logic              push, pop;

    assign in_ready = (count_q != CW'(DEPTH));
    // Writes to x0 complete the handshake but never occupy an entry.
    assign push     = in_valid && in_ready && (in_rd != 5'd0);
    // Pop looks only at the pre-edge count, so a push into an empty queue waits a cycle.
    assign pop      = (count_q != '0) && !wb_stall;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            reg_wen_q <= 1'b0;
            rd_q      <= '0;
            reg_in_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            reg_wen_q <= pop;
            if (pop) begin
                rd_q     <= mem_rd_q[head_q];
                reg_in_q <= mem_data_q[head_q];
            end
        end
    end

    // Entry storage is deliberately not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[tail_q]   <= in_rd;
            mem_data_q[tail_q] <= in_data;
        end
    end

    assign reg_wen = reg_wen_q;
    assign rd      = rd_q;
    assign reg_in  = reg_in_q;
    assign count   = count_q;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins; output stage is lowest priority.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [4:0] rs);
        logic [DATA_W:0] res;
        logic [PW-1:0]   idx;
        res = '0;
        if (rs != 5'd0) begin
            if (reg_wen_q && (rd_q == rs))
                res = {1'b1, reg_in_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (mem_rd_q[idx] == rs))
                    res = {1'b1, mem_data_q[idx]};
            end
        end
        return res;
    endfunction

    logic [DATA_W:0] fwd1_res, fwd2_res;

    always_comb begin
        fwd1_res = fwd_lookup(rs1);
        fwd2_res = fwd_lookup(rs2);
    end

    assign fwd1_hit  = fwd1_res[DATA_W];
    assign fwd1_data = fwd1_res[DATA_W-1:0];
    assign fwd2_hit  = fwd2_res[DATA_W];
    assign fwd2_data = fwd2_res[DATA_W-1:0];
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue in front of the register file's single write port. Execution units push (rd, data) results through a valid/ready handshake. The block buffers them in a DEPTH-entry FIFO and drains at most one per cycle into the register file as registered `reg_wen`/`rd`/`reg_in`. It also provides forwarding lookups so decode sees values that are not yet committed to the register file.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 32: register data width (`RegBus`).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue accepts; combinational, equals `count != DEPTH`.
- `in_rd`  in  5  destination register index.
- `in_data`  in  DATA_W  result value.
- `wb_stall`  in  1  register-file write port unavailable; blocks drain.
- `reg_wen`  out  1  write enable to register file (registered).
- `rd`  out  5  write index (registered).
- `reg_in`  out  DATA_W  write data (registered).
- `rs1`, `rs2`  in  5  lookup indices.
- `fwd1_hit`, `fwd2_hit`  out  1  pending value exists for `rs1` / `rs2`.
- `fwd1_data`, `fwd2_data`  out  DATA_W  forwarded value.
- `count`  out  log2(DEPTH)+1  occupied entries.

## Operation
- **Push:** `in_valid & in_ready` at an edge.
  - If `in_rd != 0`: write the entry at the tail; the tail pointer wraps at DEPTH.
  - If `in_rd == 0`: complete the handshake and discard the data; `count` is unchanged.
- **Pop:** at an edge where `count != 0 & !wb_stall`:
  - The head entry loads `reg_wen=1`, `rd`, `reg_in`.
  - The head pointer advances (wraps).
- **Idle drain:** at an edge with no pop, `reg_wen` loads 0. `rd`/`reg_in` hold their previous values.
- **Simultaneous push/pop:**
  - Both occur in the same edge; `count` is unchanged.
  - `in_ready` depends only on the current `count`. No full-bypass: when full, push is refused even if a pop happens that edge.
  - Empty queue: a push is not popped in the same edge. An entry spends at least one cycle in the FIFO.
- **`wb_stall`:** freezes the head; entries stay in order; pushes continue until full.
- **Forwarding** (combinational, per lookup port):
  - Candidates: all valid FIFO entries plus the output stage when `reg_wen=1`.
  - Match condition: `rs == index` and `rs != 0`.
  - Priority: youngest FIFO entry > older FIFO entries > output stage.
  - No match: `hit=0`, `data=0`.
- **Reset** (async assert, any time including mid-drain):
  - Head, tail and `count` go to 0; `reg_wen=0`, `rd=0`, `reg_in=0`.
  - All pending entries are lost; entry storage is not cleared.
  - Release is synchronous to `clk`.

## Timing
- Push at edge N → entry visible to forwarding in cycle N+1.
- Earliest pop at edge N+1 → `reg_wen=1` during cycle N+1..N+2 → register file commits at edge N+2.
- Throughput: 1 push and 1 drain per cycle sustained, with no bubbles when `wb_stall=0`.
- Forward outputs and `in_ready` have zero latency from the current state and inputs.
- Order: register-file writes occur in push order, including same-`rd` write-after-write.

## Configuration
- `WB_FWD_EN` defined: the forwarding comparators and priority mux are compiled in, as described above.
- `WB_FWD_EN` not defined: the forwarding logic is removed; `fwd1_hit`/`fwd2_hit` are tied 0 and `fwd1_data`/`fwd2_data` are tied 0. Queue behaviour is otherwise identical.

## Test plan
- **Reset mid-operation:** push 3 entries, assert `rst=0` asynchronously → `reg_wen`, `rd`, `reg_in`, `count` read 0 immediately. After release, no stale writes appear.
- **Basic latency:** single push of rd=5, data=0xDEADBEEF at edge N, `wb_stall=0` → `reg_wen=1`, `rd=5`, `reg_in=0xDEADBEEF` in cycle after edge N+1; `reg_wen=0` the following cycle.
- **Full / stall:**
  - Hold `wb_stall=1` and push 4 entries → `count=4`, `in_ready=0`; a fifth push is refused.
  - Release the stall → 4 writes drain on consecutive cycles in order.
- **x0 discard:** push rd=0, data=0x1234 → handshake completes, `count` stays 0, `reg_wen` never asserts. Lookup `rs1=0` → `fwd1_hit=0`.
- **WAW forwarding:**
  - Stall; push rd=7 with 0x11, then rd=7 with 0x22 → `rs1=7` gives `fwd1_hit=1`, `fwd1_data=0x22`.
  - After the first drain, the output stage holds 0x11 and the FIFO holds 0x22 → `fwd1_data` is still 0x22.
- **Wrap-around with concurrent push/pop:** 10 back-to-back pushes with drain enabled → `count` ≤ 1 throughout. The 10 writes emerge in order with matching rd/data; pointers wrap twice without error.
